// File: rtl/alu_ctrl_idex.sv
// ID/EX stage: decodes the MIPS opcode/funct into an ALU operation, selects and
// extends operand B, and registers the result into EX under stall/flush control.
module alu_ctrl_idex #(
  parameter int size  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             valid_ID,
  input  logic [31:0]      instr_ID,
  input  logic [size-1:0]  rs_data_ID,
  input  logic [size-1:0]  rt_data_ID,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_EX,
  output logic [3:0]       AluOp_EX,
  output logic [size-1:0]  ALU_A,
  output logic [size-1:0]  ALU_B,
  output logic [4:0]       WriteReg_EX,
  output logic             RegWrite_EX,
  output logic             illegal_EX,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SGT  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_XNOR = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  // valid_ID qualifies the ID inputs in the cycle they are sampled; valid_EX
  // marks a real instruction in EX. There is no ready: the hazard unit stalls.
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [15:0]     imm;
  logic [size-1:0] imm_sx;
  logic [size-1:0] imm_zx;

  assign opcode = instr_ID[31:26];
  assign rt     = instr_ID[20:16];
  assign rd     = instr_ID[15:11];
  assign funct  = instr_ID[5:0];
  assign imm    = instr_ID[15:0];
  assign imm_sx = {{(size-16){imm[15]}}, imm};
  assign imm_zx = {{(size-16){1'b0}}, imm};

  logic [3:0]      dec_op;
  logic [size-1:0] dec_a;
  logic [size-1:0] dec_b;
  logic [4:0]      dec_wr;
  logic            dec_rw;
  logic            dec_ill;

  always_comb begin
    dec_op  = OP_NOP;
    dec_a   = '0;
    dec_b   = '0;
    dec_wr  = 5'd0;
    dec_rw  = 1'b0;
    dec_ill = 1'b1;
    case (opcode)
      6'b000000: begin
        if (instr_ID == 32'd0) begin
          dec_ill = 1'b0;
        end else begin
          dec_ill = 1'b0;
          dec_a   = rs_data_ID;
          dec_b   = rt_data_ID;
          dec_wr  = rd;
          dec_rw  = 1'b1;
          case (funct)
            6'b100000, 6'b100001: dec_op = OP_ADD;
            6'b100010, 6'b100011: dec_op = OP_SUB;
            6'b100100:            dec_op = OP_AND;
            6'b100101:            dec_op = OP_OR;
            6'b100110:            dec_op = OP_XOR;
            6'b100111:            dec_op = OP_NOR;
            6'b101010:            dec_op = OP_SLT;
            6'b101100:            dec_op = OP_SGT;
            6'b101101:            dec_op = OP_NAND;
            6'b101110:            dec_op = OP_XNOR;
            default: begin
              dec_ill = 1'b1;
              dec_a   = '0;
              dec_b   = '0;
              dec_wr  = 5'd0;
              dec_rw  = 1'b0;
            end
          endcase
        end
      end
      6'b001000, 6'b001010, 6'b100011: begin
        dec_op  = (opcode == 6'b001010) ? OP_SLT : OP_ADD;
        dec_a   = rs_data_ID;
        dec_b   = imm_sx;
        dec_wr  = rt;
        dec_rw  = 1'b1;
        dec_ill = 1'b0;
      end
      6'b001100, 6'b001101, 6'b001110: begin
        dec_op  = (opcode == 6'b001100) ? OP_AND :
                  (opcode == 6'b001101) ? OP_OR  : OP_XOR;
        dec_a   = rs_data_ID;
        dec_b   = imm_zx;
        dec_wr  = rt;
        dec_rw  = 1'b1;
        dec_ill = 1'b0;
      end
      6'b101011: begin
        dec_op  = OP_ADD;
        dec_a   = rs_data_ID;
        dec_b   = imm_sx;
        dec_ill = 1'b0;
      end
      6'b000100, 6'b000101: begin
        dec_op  = OP_SUB;
        dec_a   = rs_data_ID;
        dec_b   = rt_data_ID;
        dec_ill = 1'b0;
      end
      default: ;
    endcase
  end

  // Flush beats stall; a held stall freezes both the EX register and the counter.
  always_ff @(posedge clk) begin
    if (Reset) begin
      valid_EX    <= 1'b0;
      AluOp_EX    <= OP_NOP;
      ALU_A       <= '0;
      ALU_B       <= '0;
      WriteReg_EX <= 5'd0;
      RegWrite_EX <= 1'b0;
      illegal_EX  <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush || (!stall && !valid_ID)) begin
      valid_EX    <= 1'b0;
      AluOp_EX    <= OP_NOP;
      ALU_A       <= '0;
      ALU_B       <= '0;
      WriteReg_EX <= 5'd0;
      RegWrite_EX <= 1'b0;
      illegal_EX  <= 1'b0;
    end else if (!stall) begin
      valid_EX    <= 1'b1;
      AluOp_EX    <= dec_op;
      ALU_A       <= dec_a;
      ALU_B       <= dec_b;
      WriteReg_EX <= dec_wr;
      RegWrite_EX <= dec_rw;
      illegal_EX  <= dec_ill;
      if (dec_ill && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_ctrl_idex.sv
// Directed bench for alu_ctrl_idex: a driver pushes hand-computed expectations,
// a monitor pops and compares one entry per cycle on the falling edge.
module tb_alu_ctrl_idex;

  logic        clk = 1'b0;
  logic        Reset;
  logic        valid_ID;
  logic [31:0] instr_ID;
  logic [31:0] rs_data_ID;
  logic [31:0] rt_data_ID;
  logic        stall;
  logic        flush;
  logic        valid_EX;
  logic [3:0]  AluOp_EX;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic [4:0]  WriteReg_EX;
  logic        RegWrite_EX;
  logic        illegal_EX;
  logic [7:0]  illegal_cnt;

  alu_ctrl_idex #(.size(32), .CNT_W(8)) dut (
    .clk(clk), .Reset(Reset), .valid_ID(valid_ID), .instr_ID(instr_ID),
    .rs_data_ID(rs_data_ID), .rt_data_ID(rt_data_ID), .stall(stall), .flush(flush),
    .valid_EX(valid_EX), .AluOp_EX(AluOp_EX), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .WriteReg_EX(WriteReg_EX), .RegWrite_EX(RegWrite_EX), .illegal_EX(illegal_EX),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk_ops;
    logic        chk_wr;
    logic        v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wr;
    logic        rw;
    logic        ill;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(logic v, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [4:0] wr, logic rw, logic ill, logic [7:0] cnt,
                              logic co, logic cw);
    exp_t e;
    e.chk_ops = co; e.chk_wr = cw; e.v = v; e.op = op; e.a = a; e.b = b;
    e.wr = wr; e.rw = rw; e.ill = ill; e.cnt = cnt;
    return e;
  endfunction

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a new EX value every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("valid_EX", {31'd0, valid_EX}, {31'd0, e.v});
      check("AluOp_EX", {28'd0, AluOp_EX}, {28'd0, e.op});
      check("RegWrite_EX", {31'd0, RegWrite_EX}, {31'd0, e.rw});
      check("illegal_EX", {31'd0, illegal_EX}, {31'd0, e.ill});
      check("illegal_cnt", {24'd0, illegal_cnt}, {24'd0, e.cnt});
      if (e.chk_ops) begin
        check("ALU_A", ALU_A, e.a);
        check("ALU_B", ALU_B, e.b);
      end
      if (e.chk_wr) check("WriteReg_EX", {27'd0, WriteReg_EX}, {27'd0, e.wr});
    end
  end

  // Drive one cycle of ID inputs and queue the EX value expected after the edge.
  task automatic cyc(logic rst, logic v, logic [31:0] ins, logic [31:0] rsd,
                     logic [31:0] rtd, logic st, logic fl, exp_t e);
    Reset = rst; valid_ID = v; instr_ID = ins; rs_data_ID = rsd; rt_data_ID = rtd;
    stall = st; flush = fl;
    exp_q.push_back(e);
    last = e;
    @(posedge clk);
    #1;
  endtask

  exp_t rst_e;
  exp_t bub;
  logic [31:0] ill_ins;
  logic [31:0] sub_ins;
  int   n;

  initial begin
    rst_e   = mk(1'b0, 4'hF, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    ill_ins = {6'b111111, 26'h0000123};
    sub_ins = rtype(5'd2, 5'd3, 5'd9, 6'b100010);

    // Reset held two cycles with a live instruction on ID.
    cyc(1, 1, rtype(5'd1, 5'd2, 5'd3, 6'b100000), 5, 7, 0, 0, rst_e);
    cyc(1, 1, rtype(5'd1, 5'd2, 5'd3, 6'b100000), 5, 7, 0, 0, rst_e);
    cyc(0, 1, rtype(5'd1, 5'd2, 5'd3, 6'b100000), 5, 7, 0, 0,
        mk(1, 4'h0, 5, 7, 5'd3, 1, 0, 0, 1, 1));
    // Extension checks.
    cyc(0, 1, itype(6'b001000, 5'd1, 5'd4, 16'hFFFF), 10, 99, 0, 0,
        mk(1, 4'h0, 10, 32'hFFFF_FFFF, 5'd4, 1, 0, 0, 1, 1));
    cyc(0, 1, itype(6'b001100, 5'd1, 5'd6, 16'hFFFF), 32'h1234, 99, 0, 0,
        mk(1, 4'h2, 32'h1234, 32'h0000_FFFF, 5'd6, 1, 0, 0, 1, 1));
    cyc(0, 1, itype(6'b001010, 5'd1, 5'd8, 16'h0005), 3, 99, 0, 0,
        mk(1, 4'h6, 3, 5, 5'd8, 1, 0, 0, 1, 1));
    cyc(0, 1, itype(6'b000100, 5'd1, 5'd2, 16'h0010), 32'h11, 32'h77, 0, 0,
        mk(1, 4'h1, 32'h11, 32'h77, 5'd0, 0, 0, 0, 1, 0));
    cyc(0, 1, itype(6'b100011, 5'd1, 5'd12, 16'hFFFC), 32'h100, 99, 0, 0,
        mk(1, 4'h0, 32'h100, 32'hFFFF_FFFC, 5'd12, 1, 0, 0, 1, 1));
    cyc(0, 1, itype(6'b101011, 5'd1, 5'd12, 16'h8000), 32'h200, 99, 0, 0,
        mk(1, 4'h0, 32'h200, 32'hFFFF_8000, 5'd0, 0, 0, 0, 1, 0));
    cyc(0, 1, itype(6'b001101, 5'd1, 5'd13, 16'h8000), 32'h1, 99, 0, 0,
        mk(1, 4'h3, 32'h1, 32'h0000_8000, 5'd13, 1, 0, 0, 1, 1));
    // Stall three cycles while ID changes, then release onto xor.
    cyc(0, 1, sub_ins, 100, 40, 0, 0, mk(1, 4'h1, 100, 40, 5'd9, 1, 0, 0, 1, 1));
    cyc(0, 1, rtype(5'd4, 5'd5, 5'd6, 6'b100101), 1, 2, 1, 0, last);
    cyc(0, 1, rtype(5'd4, 5'd5, 5'd7, 6'b100100), 3, 4, 1, 0, last);
    cyc(0, 0, rtype(5'd4, 5'd5, 5'd8, 6'b100111), 5, 6, 1, 0, last);
    cyc(0, 1, rtype(5'd4, 5'd5, 5'd10, 6'b100110), 32'hF0, 32'hFF, 0, 0,
        mk(1, 4'h5, 32'hF0, 32'hFF, 5'd10, 1, 0, 0, 1, 1));
    bub = mk(0, 4'hF, 0, 0, 5'd0, 0, 0, 0, 1, 1);
    cyc(0, 1, rtype(5'd4, 5'd5, 5'd11, 6'b100101), 7, 8, 1, 1, bub);
    // Remaining R-type functs, NOP word and valid_ID low.
    cyc(0, 1, rtype(5'd1, 5'd2, 5'd14, 6'b101100), 9, 4, 0, 0,
        mk(1, 4'h7, 9, 4, 5'd14, 1, 0, 0, 1, 1));
    cyc(0, 1, rtype(5'd1, 5'd2, 5'd15, 6'b101101), 9, 4, 0, 0,
        mk(1, 4'hD, 9, 4, 5'd15, 1, 0, 0, 1, 1));
    cyc(0, 1, rtype(5'd1, 5'd2, 5'd16, 6'b101110), 9, 4, 0, 0,
        mk(1, 4'hE, 9, 4, 5'd16, 1, 0, 0, 1, 1));
    cyc(0, 1, rtype(5'd1, 5'd2, 5'd17, 6'b100111), 9, 4, 0, 0,
        mk(1, 4'h4, 9, 4, 5'd17, 1, 0, 0, 1, 1));
    cyc(0, 1, rtype(5'd1, 5'd2, 5'd18, 6'b100011), 9, 4, 0, 0,
        mk(1, 4'h1, 9, 4, 5'd18, 1, 0, 0, 1, 1));
    cyc(0, 1, 32'd0, 0, 0, 0, 0, mk(1, 4'hF, 0, 0, 5'd0, 0, 0, 0, 0, 0));
    cyc(0, 0, rtype(5'd1, 5'd2, 5'd3, 6'b100000), 5, 7, 0, 0, bub);
    // Illegal: one load, a stalled copy and a flushed copy are not counted.
    cyc(0, 1, ill_ins, 5, 7, 0, 0, mk(1, 4'hF, 0, 0, 5'd0, 0, 1, 1, 1, 0));
    cyc(0, 1, ill_ins, 5, 7, 1, 0, last);
    cyc(0, 1, ill_ins, 5, 7, 0, 1, mk(0, 4'hF, 0, 0, 5'd0, 0, 0, 1, 1, 1));
    cyc(0, 1, rtype(5'd1, 5'd2, 5'd3, 6'b000000), 5, 7, 0, 0,
        mk(1, 4'hF, 0, 0, 5'd0, 0, 1, 2, 1, 0));
    // 298 more illegal loads: 300 counted events in total, saturating at 255.
    for (int i = 0; i < 298; i++) begin
      n = 3 + i;
      cyc(0, 1, ill_ins, 5, 7, 0, 0,
          mk(1, 4'hF, 0, 0, 5'd0, 0, 1, (n > 255) ? 8'd255 : 8'(n), 1, 0));
    end
    // Reset arriving while a sub is held by stall.
    cyc(0, 1, sub_ins, 100, 40, 0, 0, mk(1, 4'h1, 100, 40, 5'd9, 1, 0, 255, 1, 1));
    cyc(0, 1, ill_ins, 1, 2, 1, 0, last);
    cyc(1, 1, ill_ins, 1, 2, 1, 0, rst_e);
    cyc(0, 1, sub_ins, 100, 40, 0, 0, mk(1, 4'h1, 100, 40, 5'd9, 1, 0, 0, 1, 1));

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
